// File: rtl/stack_cmd_ctrl.sv
// Command front-end for a registered-input LIFO stack: strobes push/pop, waits out
// the stack latency, and returns data/status on a valid/ready response channel.
module stack_cmd_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int CNT_WIDTH   = 5,
    parameter int STK_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [DATA_WIDTH-1:0] stk_data,
    input  logic [DATA_WIDTH-1:0] stk_data_out,
    input  logic                  stk_error,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  fault
);

    localparam int WC_W = (STK_LATENCY > 1) ? $clog2(STK_LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state, state_nx;
    logic            op_q;
    logic [WC_W-1:0] wait_cnt;
    logic            reject;

    // Overflow/underflow is caught against the shadow count, so the stack never sees it.
    assign reject    = cmd_op ? (count == '0) : (count == CNT_WIDTH'(DEPTH));
    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign stk_push  = (state == S_ISSUE) && !op_q;
    assign stk_pop   = (state == S_ISSUE) && op_q;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nx = reject ? S_RESP : S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (wait_cnt == '0) state_nx = S_RESP;
            S_RESP:  if (rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= 1'b0;
            wait_cnt <= '0;
            stk_data <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            count    <= '0;
            fault    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        stk_data <= cmd_data;
                        rsp_data <= '0;
                        rsp_err  <= reject;
                    end
                end
                S_ISSUE: wait_cnt <= WC_W'(STK_LATENCY - 1);
                S_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else if (stk_error) begin
                        // Stack disagrees with the shadow count: report and latch the fault.
                        rsp_err <= 1'b1;
                        fault   <= 1'b1;
                    end else if (op_q) begin
                        count    <= count - 1'b1;
                        rsp_data <= stk_data_out;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// Scoreboard bench for stack_cmd_ctrl with a behavioural 16-entry stack model.
module tb_stack_cmd_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       stk_push, stk_pop;
    logic [7:0] stk_data;
    logic [7:0] stk_data_out;
    logic       stk_error;
    logic [4:0] count;
    logic       fault;

    stack_cmd_ctrl #(.DATA_WIDTH(8), .DEPTH(16), .CNT_WIDTH(5), .STK_LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data(stk_data),
        .stk_data_out(stk_data_out), .stk_error(stk_error),
        .count(count), .fault(fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural stack: registered inputs, outputs held until the next strobe.
    logic [7:0] mem [16];
    int         sp;
    logic       err_inject = 1'b0;
    int         push_n = 0, pop_n = 0, both_n = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp           <= 0;
            stk_data_out <= 8'h00;
            stk_error    <= 1'b0;
        end else begin
            if (stk_push) begin
                if (err_inject || sp == 16) stk_error <= 1'b1;
                else begin
                    mem[sp]   <= stk_data;
                    sp        <= sp + 1;
                    stk_error <= 1'b0;
                end
            end else if (stk_pop) begin
                if (err_inject || sp == 0) stk_error <= 1'b1;
                else begin
                    stk_data_out <= mem[sp-1];
                    sp           <= sp - 1;
                    stk_error    <= 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (stk_push) push_n <= push_n + 1;
        if (stk_pop) pop_n <= pop_n + 1;
        if (stk_push && stk_pop) both_n <= both_n + 1;
    end

    typedef struct {
        logic [7:0] d;
        logic       e;
        logic [4:0] c;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: every accepted response is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.d});
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.e});
                chk("count", {27'd0, count}, {27'd0, e.c});
            end
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic e, input logic [4:0] c);
        exp_t x;
        x.d = d; x.e = e; x.c = c;
        exp_q.push_back(x);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) chk("cmd_ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one command, check edge latency to rsp_valid; the monitor checks the payload.
    task automatic do_cmd(input logic op, input logic [7:0] d, input int exp_lat,
                          input logic [7:0] ed, input logic ee, input logic [4:0] ec);
        int lat;
        push_exp(ed, ee, ec);
        wait_idle();
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        @(posedge clk); #1;
    endtask

    initial begin
        int p0;
        logic [7:0] held;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_stk_push", {31'd0, stk_push}, 32'd0);
        chk("rst_stk_pop", {31'd0, stk_pop}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Pop on an empty stack is rejected locally.
        p0 = pop_n;
        do_cmd(1'b1, 8'h00, 1, 8'h00, 1'b1, 5'd0);
        chk("underflow_no_pop", pop_n, p0);

        // Single push/pop round trip.
        do_cmd(1'b0, 8'hA5, 4, 8'h00, 1'b0, 5'd1);
        do_cmd(1'b1, 8'h00, 4, 8'hA5, 1'b0, 5'd0);

        // Fill, then overflow.
        for (int i = 1; i <= 16; i++)
            do_cmd(1'b0, 8'(i), 4, 8'h00, 1'b0, 5'(i));
        p0 = push_n;
        do_cmd(1'b0, 8'hEE, 1, 8'h00, 1'b1, 5'd16);
        chk("overflow_no_push", push_n, p0);

        // Drain in LIFO order.
        for (int i = 16; i >= 1; i--)
            do_cmd(1'b1, 8'h00, 4, 8'(i), 1'b0, 5'(i - 1));

        // Response back-pressure.
        push_exp(8'h00, 1'b0, 5'd1);
        wait_idle();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 8'h3C;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_rsp_valid_rise", {31'd0, rsp_valid}, 32'd1);
        held = rsp_data;
        p0 = push_n;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data", {24'd0, rsp_data}, {24'd0, held});
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        chk("bp_no_accept", push_n, p0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;

        // Reset during WAIT of a push abandons it.
        wait_idle();
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 8'h88;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_stk_data", {24'd0, stk_data}, 32'h88);
        reset = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_stk_data", {24'd0, stk_data}, 32'd0);
        chk("mid_rst_count", {27'd0, count}, 32'd0);
        chk("mid_rst_push", {31'd0, stk_push}, 32'd0);
        chk("mid_rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        p0 = pop_n;
        do_cmd(1'b1, 8'h00, 1, 8'h00, 1'b1, 5'd0);
        chk("post_rst_no_pop", pop_n, p0);

        // Stack error on a legal push.
        chk("fault_before", {31'd0, fault}, 32'd0);
        err_inject = 1'b1;
        do_cmd(1'b0, 8'h42, 4, 8'h00, 1'b1, 5'd0);
        err_inject = 1'b0;
        chk("fault_set", {31'd0, fault}, 32'd1);
        do_cmd(1'b0, 8'h43, 4, 8'h00, 1'b0, 5'd1);
        chk("fault_sticky", {31'd0, fault}, 32'd1);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("push_pop_exclusive", both_n, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
